// File: rtl/bias_relu_quant_pkg.sv
// Shared CNN datapath constants, types and the requantisation helper used by
// the conv post-accumulation stage and the FC layer.
package cnn_pkg;

  localparam int unsigned NUM_CH    = 6;
  localparam int unsigned ACC_W     = 24;
  localparam int unsigned BIAS_W    = 24;
  localparam int unsigned OUT_W     = 8;
  localparam int unsigned CH_W      = 3;
  localparam int unsigned DEF_SHIFT = 12;
  localparam int unsigned SUM_W     = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [BIAS_W-1:0] bias_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic [OUT_W-1:0]         pix_t;

  // ReLU, round-half-up right shift, then clamp to the unsigned activation range.
  function automatic pix_t requant_relu_sat(input sum_t sum, input int unsigned shift);
    logic [SUM_W:0] rnd;
    if (sum[SUM_W-1]) return '0;
    rnd = {1'b0, sum} + ((SUM_W+1)'(1) << (shift - 1));
    rnd = rnd >> shift;
    if (|rnd[SUM_W:OUT_W]) return '1;
    return rnd[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/bias_relu_quant_if.sv
// Accumulator-in / activation-out valid-ready streams of the bias/ReLU/quant stage.
interface bias_relu_quant_if;
  import cnn_pkg::*;

  logic              in_valid;
  logic              in_ready;
  acc_t              in_data;
  logic              out_valid;
  logic              out_ready;
  pix_t              out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );
endinterface

// File: rtl/bias_relu_quant.sv
// Conv post-accumulation: bias add (bias fetched from an external registered ROM),
// ReLU, rounding shift and saturation to an 8-bit activation, 2-stage pipeline.
module bias_relu_quant
  import cnn_pkg::*;
#(
  parameter int unsigned SHIFT = DEF_SHIFT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ch_clr,
  bias_relu_quant_if.slave bus,
  output logic [CH_W-1:0] rom_aa,
  output logic            rom_cena,
  input  bias_t           rom_qa
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic            w_en;
  logic            w_accept;
  logic [CH_W-1:0] w_ch;

  logic [CH_W-1:0] r_ch_cnt;
  logic            r_v1;
  acc_t            r_acc;
  logic [CH_W-1:0] r_ch1;
  logic            r_v2;
  sum_t            r_sum;
  logic [CH_W-1:0] r_ch2;
  logic            r_out_valid;
  pix_t            r_out_data;
  logic [CH_W-1:0] r_out_ch;
  logic            r_out_last;

  // A beat taken together with ch_clr is channel 0, so the ROM address follows the clear too.
  always_comb begin
    w_en     = ~r_out_valid | bus.out_ready;
    w_accept = bus.in_valid & w_en & rstn;
    w_ch     = ch_clr ? '0 : r_ch_cnt;
  end

  assign bus.in_ready  = w_en & rstn;
  assign rom_cena      = ~w_accept;
  assign rom_aa        = w_ch;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_last  = r_out_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ch_cnt <= '0;
    end else if (w_accept) begin
      r_ch_cnt <= (w_ch == LAST_CH) ? '0 : w_ch + 1'b1;
    end else if (ch_clr) begin
      r_ch_cnt <= '0;
    end
  end

  // rom_qa stays valid across a stall between S1 and S2 because no read is issued then.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1        <= 1'b0;
      r_acc       <= '0;
      r_ch1       <= '0;
      r_v2        <= 1'b0;
      r_sum       <= '0;
      r_ch2       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_en) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_acc <= bus.in_data;
        r_ch1 <= w_ch;
      end
      r_v2        <= r_v1;
      r_sum       <= sum_t'(r_acc) + sum_t'(rom_qa);
      r_ch2       <= r_ch1;
      r_out_valid <= r_v2;
      r_out_data  <= requant_relu_sat(r_sum, SHIFT);
      r_out_ch    <= r_ch2;
      r_out_last  <= (r_ch2 == LAST_CH);
    end
  end

endmodule
